// File: rtl/frame_stuffer_tx_pkg.sv
// Shared framing constants, frame/status codes and the transmit FSM encoding
// for the JAWNY/TAJNY byte channel.
package frame_stuffer_tx_pkg;

  localparam logic [7:0] FRAME_START = 8'h06;
  localparam logic [7:0] FRAME_END   = 8'h07;
  localparam logic [7:0] ESC_VAL     = 8'h14;
  localparam logic [7:0] ESC_XOR     = 8'h20;

  localparam int PREAMBLE_SIZE = 3;
  localparam int DATA_SIZE     = 64;
  localparam int CRC_SIZE      = 8;
  localparam int NONCE_SIZE    = 12;
  localparam int FRAME_BYTES_DEFAULT = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE;

  typedef enum logic [1:0] {
    FIRST_FRAME = 2'd0,
    LAST_FRAME  = 2'd1,
    NORMALNA    = 2'd2,
    POJEDYNCZA  = 2'd3
  } frame_type_e;

  typedef enum logic [1:0] {
    OKAY        = 2'd0,
    ERROR       = 2'd1,
    FATAL_ERROR = 2'd2
  } status_e;

  // ST_ESC1 carries the escape marker on the wire; ST_ESC2 the masked byte.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BYTE  = 3'd2,
    ST_ESC1  = 3'd3,
    ST_ESC2  = 3'd4,
    ST_END   = 3'd5
  } state_e;

endpackage

// File: rtl/frame_stuffer_tx_if.sv
// Frame-in / byte-out handshake bundle between Core, the framer and the UART.
interface frame_stuffer_tx_if #(
  parameter int FRAME_BYTES = 75
);
  logic [0:FRAME_BYTES*8-1] fin;
  logic                     fin_valid;
  logic                     fin_ready;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic                     busy;
  logic                     frame_done;

  modport master (
    output fin, fin_valid, tx_ready,
    input  fin_ready, tx_data, tx_valid, busy, frame_done
  );

  modport slave (
    input  fin, fin_valid, tx_ready,
    output fin_ready, tx_data, tx_valid, busy, frame_done
  );
endinterface

// File: rtl/frame_stuffer_tx.sv
// Transmit framer: wraps one captured frame in FRAME_START/FRAME_END and
// byte-stuffs flag/escape values in the payload. All outputs are registered.
module frame_stuffer_tx
  import frame_stuffer_tx_pkg::*;
#(
  parameter int FRAME_BYTES = 75
) (
  input  logic              clk,
  input  logic              rst_n,
  frame_stuffer_tx_if.slave bus
);

  localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  function automatic logic needs_esc(input logic [7:0] b);
    return (b == FRAME_START) || (b == FRAME_END) || (b == ESC_VAL);
  endfunction

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [0:FRAME_BYTES*8-1] frame_q, frame_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_valid_q, tx_valid_d;
  logic                     busy_q, busy_d;
  logic                     fin_ready_q, fin_ready_d;
  logic                     frame_done_q, frame_done_d;

  logic [7:0]       bytes_s [FRAME_BYTES];
  logic             xfer_s;
  logic             last_s;
  logic [IDX_W-1:0] load_idx_s;
  logic [7:0]       load_byte_s;
  logic [7:0]       cur_byte_s;

  for (genvar k = 0; k < FRAME_BYTES; k++) begin : g_bytes
    assign bytes_s[k] = frame_q[8*k +: 8];
  end

  assign xfer_s      = tx_valid_q & bus.tx_ready;
  assign last_s      = (idx_q == LAST_IDX);
  assign load_byte_s = bytes_s[load_idx_s];
  assign cur_byte_s  = bytes_s[idx_q];

  // Byte to load next: byte 0 right after the start flag, otherwise the successor.
  always_comb begin
    load_idx_s = idx_q;
    if ((state_q == ST_START) || last_s) begin
      load_idx_s = idx_q;
    end else begin
      load_idx_s = idx_q + IDX_W'(1);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = busy_q;
    fin_ready_d  = fin_ready_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.fin_valid && fin_ready_q) begin
          frame_d     = bus.fin;
          tx_data_d   = FRAME_START;
          tx_valid_d  = 1'b1;
          idx_d       = '0;
          busy_d      = 1'b1;
          fin_ready_d = 1'b0;
          state_d     = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START, ST_BYTE, ST_ESC2: begin
        if (xfer_s && (state_q != ST_START) && last_s) begin
          tx_data_d = FRAME_END;
          state_d   = ST_END;
        end else if (xfer_s) begin
          idx_d = load_idx_s;
          if (needs_esc(load_byte_s)) begin
            tx_data_d = ESC_VAL;
            state_d   = ST_ESC1;
          end else begin
            tx_data_d = load_byte_s;
            state_d   = ST_BYTE;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_ESC1: begin
        if (xfer_s) begin
          tx_data_d = cur_byte_s ^ ESC_XOR;
          state_d   = ST_ESC2;
        end else begin
          state_d = ST_ESC1;
        end
      end
      ST_END: begin
        if (xfer_s) begin
          tx_valid_d   = 1'b0;
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          fin_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_END;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        tx_valid_d  = 1'b0;
        busy_d      = 1'b0;
        fin_ready_d = 1'b1;
      end
    endcase
  end

  // State, counter, frame and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      frame_q      <= '0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      fin_ready_q  <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      fin_ready_q  <= fin_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.busy       = busy_q;
  assign bus.fin_ready  = fin_ready_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_stuffer_tx.sv
// Directed bench for frame_stuffer_tx with 4-byte frames: table of frames
// with expected wire bytes, plus reset and idle sequences.
module tb_frame_stuffer_tx;
  import frame_stuffer_tx_pkg::*;

  localparam int FB = 4;
  localparam logic [0:15] STALL_PAT = 16'b1010_0000_1101_1111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  frame_stuffer_tx_if #(.FRAME_BYTES(FB)) bus ();

  frame_stuffer_tx #(.FRAME_BYTES(FB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // mode 0: tx_ready high, 1: stall pattern, 2: intruding fin_valid mid-frame
  typedef struct {
    logic [31:0] fin;
    int          mode;
    int          len;
    logic [95:0] exp;
  } vec_t;

  vec_t vecs [8];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic run_frame(input int id, input vec_t v);
    int k = 0;
    int cyc = 0;
    bit done = 1'b0;
    logic stalled = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    @(negedge clk);
    check($sformatf("v%0d_fin_ready_idle", id), 32'(bus.fin_ready), 32'd1);
    bus.fin = v.fin;
    bus.fin_valid = 1'b1;
    @(negedge clk);
    bus.fin_valid = 1'b0;
    bus.fin = 32'hDEAD_BEEF;
    check($sformatf("v%0d_busy_accept", id), 32'(bus.busy), 32'd1);
    check($sformatf("v%0d_fin_ready_accept", id), 32'(bus.fin_ready), 32'd0);
    while (!done && cyc < 200) begin
      if (v.mode == 1) bus.tx_ready = STALL_PAT[cyc % 16];
      else bus.tx_ready = 1'b1;
      if (v.mode == 2) begin
        bus.fin = 32'hAABB_CCDD;
        bus.fin_valid = (k == 2 || k == 3);
      end
      if (stalled) begin
        check($sformatf("v%0d_stall_valid", id), 32'(bus.tx_valid), 32'd1);
        check($sformatf("v%0d_stall_data", id), 32'(bus.tx_data), 32'(held));
      end
      if (v.mode != 1) check($sformatf("v%0d_no_gap", id), 32'(bus.tx_valid), 32'd1);
      check($sformatf("v%0d_done_low", id), 32'(bus.frame_done), 32'd0);
      stalled = bus.tx_valid && !bus.tx_ready;
      held = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
        e = v.exp[95 - 8*k -: 8];
        check($sformatf("v%0d_byte%0d", id, k), 32'(bus.tx_data), 32'(e));
        k++;
        if (k == v.len) done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.fin_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL v%0d_timeout: got %0d bytes expected %0d", id, k, v.len);
    end else begin
      check($sformatf("v%0d_frame_done", id), 32'(bus.frame_done), 32'd1);
      check($sformatf("v%0d_busy_end", id), 32'(bus.busy), 32'd0);
      check($sformatf("v%0d_fin_ready_end", id), 32'(bus.fin_ready), 32'd1);
      check($sformatf("v%0d_tx_valid_end", id), 32'(bus.tx_valid), 32'd0);
      check($sformatf("v%0d_idx_final", id), 32'(dut.idx_q), 32'(FB - 1));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", id), 32'(bus.frame_done), 32'd0);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{fin: 32'h1122_3344, mode: 0, len: 6,  exp: 96'h06_11_22_33_44_07_00_00_00_00_00_00};
    vecs[1] = '{fin: 32'h0607_1441, mode: 0, len: 9,  exp: 96'h06_14_26_14_27_14_34_41_07_00_00_00};
    vecs[2] = '{fin: 32'h1122_3344, mode: 1, len: 6,  exp: 96'h06_11_22_33_44_07_00_00_00_00_00_00};
    vecs[3] = '{fin: 32'h1122_3344, mode: 2, len: 6,  exp: 96'h06_11_22_33_44_07_00_00_00_00_00_00};
    vecs[4] = '{fin: 32'hAABB_CCDD, mode: 0, len: 6,  exp: 96'h06_AA_BB_CC_DD_07_00_00_00_00_00_00};
    vecs[5] = '{fin: 32'h0000_0007, mode: 0, len: 7,  exp: 96'h06_00_00_00_14_27_07_00_00_00_00_00};
    vecs[6] = '{fin: 32'h2005_0815, mode: 1, len: 6,  exp: 96'h06_20_05_08_15_07_00_00_00_00_00_00};
    vecs[7] = '{fin: 32'h1414_1414, mode: 1, len: 10, exp: 96'h06_14_34_14_34_14_34_14_34_07_00_00};

    bus.fin = 32'h0;
    bus.fin_valid = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_fin_ready", 32'(bus.fin_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;

    @(negedge clk);
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("idle_ready_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 8; i++) run_frame(i, vecs[i]);

    @(negedge clk);
    bus.tx_ready = 1'b1;
    bus.fin = 32'h1122_3344;
    bus.fin_valid = 1'b1;
    @(negedge clk);
    bus.fin_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (bus.tx_valid && bus.tx_ready) n++;
      @(negedge clk);
    end
    check("rst_mid_bytes", 32'(n), 32'd3);
    check("rst_mid_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_mid_fin_ready", 32'(bus.fin_ready), 32'd1);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_tx_data", 32'(bus.tx_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(8, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
